// File: rtl/modn_pkg.sv
// Shared constants and elaboration helpers for the synchronous modulo-N counter.
package modn_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam int   WRAPCNT_W = 8;

    // Legal when 2 <= modulus <= 2**width; width is capped so the shift stays in int range.
    function automatic bit modulus_ok(input int width, input int modulus);
        if (width < 1 || width > 30) begin
            return 1'b0;
        end
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/modn_counter_if.sv
// Control/status bundle for modn_counter; wrap_cnt exists only with MODN_COUNTER_WRAPCNT_EN.
interface modn_counter_if #(
    parameter int WIDTH = 2
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             load_err;
`ifdef MODN_COUNTER_WRAPCNT_EN
    logic [modn_pkg::WRAPCNT_W-1:0] wrap_cnt;
`endif

    modport master (
        output clear, load, load_val, en, up,
`ifdef MODN_COUNTER_WRAPCNT_EN
        input  wrap_cnt,
`endif
        input  q, tc, wrap, load_err
    );

    modport slave (
        input  clear, load, load_val, en, up,
`ifdef MODN_COUNTER_WRAPCNT_EN
        output wrap_cnt,
`endif
        output q, tc, wrap, load_err
    );
endinterface

// File: rtl/modn_step.sv
// Combinational next-count and terminal-count for a modulo-MODULUS counter.
module modn_step
    import modn_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 3
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic w_at_max;
    logic w_at_zero;

    // Explicit compare against MODULUS-1 so MODULUS==2**WIDTH needs no special case.
    assign w_at_max  = (i_q == MAX_VAL);
    assign w_at_zero = (i_q == '0);
    assign o_tc      = (i_up == DIR_UP) ? w_at_max : w_at_zero;

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        o_next = i_q;
        if (i_up == DIR_UP) begin
            o_next = w_at_max ? '0 : i_q + 1'b1;
        end else begin
            o_next = w_at_zero ? MAX_VAL : i_q - 1'b1;
        end
    end
endmodule

// File: rtl/modn_counter.sv
// Synchronous up/down modulo-N counter with clear, checked load, tc and wrap pulse.
// Optional saturating wrap counter enabled by defining MODN_COUNTER_WRAPCNT_EN.
module modn_counter
    import modn_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 3
) (
    input  logic            clk,
    input  logic            reset,
    modn_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("modn_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_load_err;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;
    logic             w_load_ok;

    modn_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .i_q    (r_q),
        .i_up   (bus.up),
        .o_next (w_next),
        .o_tc   (w_tc)
    );

    assign w_load_ok = (bus.load_val <= MAX_VAL);

    // Priority: clear > load > count > hold.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.clear) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.load) begin
            if (w_load_ok) begin
                r_q <= bus.load_val;
            end else begin
                r_load_err <= 1'b1;
            end
            r_wrap <= 1'b0;
        end else if (bus.en) begin
            r_q    <= w_next;
            r_wrap <= w_tc;
        end else begin
            r_wrap <= 1'b0;
        end
    end

`ifdef MODN_COUNTER_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] r_wrap_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap_cnt <= '0;
        end else if (bus.clear) begin
            r_wrap_cnt <= '0;
        end else if (!bus.load && bus.en && w_tc && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`endif

    assign bus.q        = r_q;
    assign bus.tc       = w_tc;
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_load_err;
endmodule
